// File: rtl/router_pkg.sv
// Shared types for the router input-port receiver: FSM states, byte/address widths
// and the beat record carried from the serial decoder to the switch fabric.
package router_pkg;

  localparam int ADDR_W = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    PAD  = 2'd2,
    DATA = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic [ADDR_W-1:0] da;
    logic              sop;
    logic              eop;
  } rx_beat_t;

  // Assemble one buffered beat from its fields.
  function automatic rx_beat_t mk_beat(input logic [BYTE_W-1:0] data,
                                       input logic [ADDR_W-1:0] da,
                                       input logic              sop,
                                       input logic              eop);
    rx_beat_t b;
    b.data = data;
    b.da   = da;
    b.sop  = sop;
    b.eop  = eop;
    return b;
  endfunction

endpackage

// File: rtl/router_rx_fifo.sv
// First-word-fall-through beat buffer; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module router_rx_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  rx_beat_t push_beat,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output rx_beat_t head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_r;
  logic [PTR_W:0] rd_ptr_r;
  rx_beat_t       mem_r [DEPTH];
  logic           wr_en_s;
  logic           rd_en_s;

  assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                 (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);

  // A push into a full buffer is still taken when the head leaves on the same edge.
  assign wr_en_s = push && (!full || pop);
  assign rd_en_s = pop && !empty;

  // Head is forced to zero while empty so stale entries never reach the port.
  assign head = empty ? '0 : mem_r[rd_ptr_r[PTR_W-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= push_beat;
    end
  end

endmodule

// File: rtl/router_rx_port.sv
// One router input channel: decodes address, pad and LSB-first payload bits from
// the serial line and streams tagged bytes to the fabric through a small buffer.
module router_rx_port
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PAD_CYCLES = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              frame_n,
  input  logic              valid_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_da,
  output logic              out_sop,
  output logic              out_eop,
  output logic              err_frame,
  output logic              err_ovf,
  output logic              busy
);

  localparam int PAD_W = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;

  rx_state_e         state_r, state_s;
  logic [2:0]        bit_cnt_r, bit_cnt_s;
  logic [PAD_W-1:0]  pad_cnt_r, pad_cnt_s;
  logic [ADDR_W-1:0] da_r, da_s;
  logic [BYTE_W-1:0] shift_r, shift_s;
  logic              first_r, first_s;
  logic              push_s;
  rx_beat_t          push_beat_s;
  logic              err_frame_s;
  logic              err_frame_r;
  logic              err_ovf_r;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  rx_beat_t          head_s;

  // Next-state and datapath decode for the serial packet format.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    pad_cnt_s   = pad_cnt_r;
    da_s        = da_r;
    shift_s     = shift_r;
    first_s     = first_r;
    push_s      = 1'b0;
    push_beat_s = '0;
    err_frame_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!frame_n) begin
          da_s      = {{(ADDR_W-1){1'b0}}, din};
          bit_cnt_s = 3'd1;
          state_s   = ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (frame_n) begin
          err_frame_s = 1'b1;
          bit_cnt_s   = 3'd0;
          state_s     = IDLE;
        end else begin
          da_s[bit_cnt_r[1:0]] = din;
          if (bit_cnt_r == 3'(ADDR_W - 1)) begin
            bit_cnt_s = 3'd0;
            pad_cnt_s = '0;
            state_s   = PAD;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end
      end
      PAD: begin
        if (frame_n) begin
          err_frame_s = 1'b1;
          pad_cnt_s   = '0;
          state_s     = IDLE;
        end else if (pad_cnt_r == PAD_W'(PAD_CYCLES - 1)) begin
          pad_cnt_s = '0;
          bit_cnt_s = 3'd0;
          first_s   = 1'b1;
          state_s   = DATA;
        end else begin
          pad_cnt_s = pad_cnt_r + {{(PAD_W-1){1'b0}}, 1'b1};
        end
      end
      DATA: begin
        if (!valid_n) begin
          shift_s[bit_cnt_r] = din;
          if (bit_cnt_r == 3'd7) begin
            // frame_n high on the last valid bit is the only clean end of packet.
            push_s      = 1'b1;
            push_beat_s = mk_beat(shift_s, da_r, first_r, frame_n);
            first_s     = 1'b0;
            bit_cnt_s   = 3'd0;
            state_s     = frame_n ? IDLE : DATA;
          end else if (frame_n) begin
            err_frame_s = 1'b1;
            bit_cnt_s   = 3'd0;
            state_s     = IDLE;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else if (frame_n) begin
          err_frame_s = 1'b1;
          bit_cnt_s   = 3'd0;
          state_s     = IDLE;
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign pop_s = !empty_s && out_ready;

  // State, counters, shift/address registers and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      pad_cnt_r   <= '0;
      da_r        <= '0;
      shift_r     <= '0;
      first_r     <= 1'b0;
      err_frame_r <= 1'b0;
      err_ovf_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      pad_cnt_r   <= pad_cnt_s;
      da_r        <= da_s;
      shift_r     <= shift_s;
      first_r     <= first_s;
      err_frame_r <= err_frame_s;
      err_ovf_r   <= push_s && full_s && !pop_s;
    end
  end

  router_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_beat (push_beat_s),
    .pop       (pop_s),
    .full      (full_s),
    .empty     (empty_s),
    .head      (head_s)
  );

  assign out_valid = !empty_s;
  assign out_data  = head_s.data;
  assign out_da    = head_s.da;
  assign out_sop   = head_s.sop;
  assign out_eop   = head_s.eop;
  assign err_frame = err_frame_r;
  assign err_ovf   = err_ovf_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_router_rx_port.sv
// Bench for router_rx_port: packet-level stimulus expanded into per-cycle records,
// a queue model of the byte buffer, a vector table and random packet traffic.
module tb_router_rx_port;
  import router_pkg::*;

  localparam int DEPTH = 4;
  localparam int PAD   = 5;

  logic       clk = 1'b0;
  logic       reset, din, frame_n, valid_n, out_ready;
  logic       out_valid, out_sop, out_eop, err_frame, err_ovf, busy;
  logic [7:0] out_data;
  logic [3:0] out_da;

  always #5 clk = ~clk;

  router_rx_port #(.FIFO_DEPTH(DEPTH), .PAD_CYCLES(PAD)) dut (
    .clk(clk), .reset(reset), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_da(out_da),
    .out_sop(out_sop), .out_eop(out_eop), .err_frame(err_frame), .err_ovf(err_ovf),
    .busy(busy)
  );

  // One line cycle: inputs plus what the packet format says must follow from it.
  typedef struct {
    logic din, frame_n, valid_n, ready;
    logic push;
    rx_beat_t beat;
    logic err, busy_next, pos7;
  } cyc_t;

  typedef struct {
    logic [3:0]  da;
    int          n;
    logic [47:0] bytes;
    int          abort_k;
    int          stall_at;
    int          stall_len;
  } pkt_t;

  typedef struct {
    pkt_t        pk0, pk1;
    int          npk, rmode, exp_n;
    logic [47:0] exp_data;
    logic [23:0] exp_da;
    logic [5:0]  exp_sop, exp_eop;
    int          exp_ovf, exp_err, exp_first;
  } vec_t;

  cyc_t     cyc_q[$];
  rx_beat_t mq[$];
  rx_beat_t obs_q[$];
  logic     exp_ef, exp_ov, exp_busy;
  int       n_pass, n_total, ef_cnt, ov_cnt, first_seen, cyc_idx;
  vec_t     vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("head_beat", 32'({out_data, out_da, out_sop, out_eop}), 32'(mq[0]));
    chk("err_frame", 32'(err_frame), 32'(exp_ef));
    chk("err_ovf", 32'(err_ovf), 32'(exp_ov));
    chk("busy", 32'(busy), 32'(exp_busy));
    if (err_frame === 1'b1) ef_cnt++;
    if (err_ovf === 1'b1) ov_cnt++;
    if (out_valid === 1'b1 && first_seen < 0) first_seen = cyc_idx;
  endtask

  task automatic do_cycle(input cyc_t c);
    @(negedge clk);
    check_outputs();
    din = c.din; frame_n = c.frame_n; valid_n = c.valid_n; out_ready = c.ready;
    if (out_valid === 1'b1 && c.ready) obs_q.push_back(rx_beat_t'({out_data, out_da, out_sop, out_eop}));
    if (c.ready && mq.size() != 0) void'(mq.pop_front());
    exp_ov = 1'b0;
    if (c.push) begin
      if (mq.size() < DEPTH) mq.push_back(c.beat);
      else exp_ov = 1'b1;
    end
    exp_ef = c.err;
    exp_busy = c.busy_next;
    cyc_idx++;
  endtask

  task automatic run_q();
    cyc_t c;
    while (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      do_cycle(c);
    end
  endtask

  function automatic cyc_t blank(input int rmode);
    cyc_t c;
    c.din = 1'($urandom); c.frame_n = 1'b1; c.valid_n = 1'($urandom);
    c.ready = (rmode == 2) ? ($urandom_range(0, 9) < 7) : (rmode == 1);
    c.push = 1'b0; c.beat = '0; c.err = 1'b0; c.busy_next = 1'b0; c.pos7 = 1'b0;
    return c;
  endfunction

  function automatic pkt_t pk(input logic [3:0] da, input int n, input logic [47:0] bytes,
                              input int abort_k, input int stall_at, input int stall_len);
    pkt_t p;
    p.da = da; p.n = n; p.bytes = bytes; p.abort_k = abort_k;
    p.stall_at = stall_at; p.stall_len = stall_len;
    return p;
  endfunction

  // Expand a packet into line cycles; abort_k replaces cycle k (and drops the rest) by frame_n high.
  task automatic add_pkt(input pkt_t p, input int rmode);
    cyc_t t[$];
    cyc_t c;
    int   bit_no = 0;
    int   ns, k_ab;
    logic last, p7;
    for (int i = 0; i < 4; i++) begin
      c = blank(rmode); c.din = p.da[i]; c.frame_n = 1'b0; c.busy_next = 1'b1; t.push_back(c);
    end
    for (int i = 0; i < PAD; i++) begin
      c = blank(rmode); c.frame_n = 1'b0; c.busy_next = 1'b1; t.push_back(c);
    end
    for (int b = 0; b < p.n; b++) begin
      for (int k = 0; k < 8; k++) begin
        ns = (bit_no == p.stall_at) ? p.stall_len :
             ((rmode == 2 && $urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0);
        for (int s = 0; s < ns; s++) begin
          c = blank(rmode); c.frame_n = 1'b0; c.valid_n = 1'b1; c.busy_next = 1'b1;
          c.pos7 = (k == 7); t.push_back(c);
        end
        last = (b == p.n - 1) && (k == 7);
        c = blank(rmode); c.valid_n = 1'b0; c.din = p.bytes[8*b + k]; c.frame_n = last;
        c.busy_next = !last; c.pos7 = (k == 7);
        if (k == 7) begin
          c.push = 1'b1;
          c.beat = mk_beat(p.bytes[8*b +: 8], p.da, b == 0, b == p.n - 1);
        end
        t.push_back(c);
        bit_no++;
      end
    end
    k_ab = (p.abort_k == -2) ? $urandom_range(1, t.size() - 1) : p.abort_k;
    if (k_ab > 0 && k_ab < t.size()) begin
      p7 = t[k_ab].pos7;
      while (t.size() > k_ab) void'(t.pop_back());
      c = blank(rmode); c.frame_n = 1'b1; c.err = 1'b1; c.busy_next = 1'b0;
      if (p7) c.valid_n = 1'b1;
      t.push_back(c);
    end
    foreach (t[i]) cyc_q.push_back(t[i]);
  endtask

  task automatic add_idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) cyc_q.push_back(blank(rmode));
  endtask

  task automatic start_scenario();
    obs_q.delete(); ef_cnt = 0; ov_cnt = 0; first_seen = -1; cyc_idx = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    rx_beat_t e;
    start_scenario();
    add_pkt(v.pk0, v.rmode);
    if (v.npk > 1) add_pkt(v.pk1, v.rmode);
    add_idle(12, 1);
    run_q();
    chk($sformatf("v%0d_beats", idx), 32'(obs_q.size()), 32'(v.exp_n));
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      e = mk_beat(v.exp_data[8*i +: 8], v.exp_da[4*i +: 4], v.exp_sop[i], v.exp_eop[i]);
      chk($sformatf("v%0d_beat%0d", idx, i), 32'(obs_q[i]), 32'(e));
    end
    chk($sformatf("v%0d_err_frame_cnt", idx), 32'(ef_cnt), 32'(v.exp_err));
    chk($sformatf("v%0d_err_ovf_cnt", idx), 32'(ov_cnt), 32'(v.exp_ovf));
    chk($sformatf("v%0d_first_valid", idx), 32'(first_seen), 32'(v.exp_first));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_valid_sop_eop", 32'({out_valid, out_sop, out_eop}), 32'd0);
    chk("rst_data_da", 32'({out_data, out_da}), 32'd0);
    chk("rst_errs_busy", 32'({err_frame, err_ovf, busy}), 32'd0);
    reset = 1'b0;
    mq.delete(); exp_ef = 1'b0; exp_ov = 1'b0; exp_busy = 1'b0;
  endtask

  function automatic vec_t mkv(input pkt_t a, input pkt_t b, input int npk, input int rmode,
                               input int n, input logic [47:0] d, input logic [23:0] da,
                               input logic [5:0] sop, input logic [5:0] eop,
                               input int ovf, input int err, input int first);
    vec_t v;
    v.pk0 = a; v.pk1 = b; v.npk = npk; v.rmode = rmode; v.exp_n = n; v.exp_data = d;
    v.exp_da = da; v.exp_sop = sop; v.exp_eop = eop; v.exp_ovf = ovf; v.exp_err = err;
    v.exp_first = first;
    return v;
  endfunction

  initial begin
    pkt_t none, p;
    n_pass = 0; n_total = 0;
    reset = 1'b1; din = 1'b0; frame_n = 1'b1; valid_n = 1'b1; out_ready = 1'b0;
    exp_ef = 1'b0; exp_ov = 1'b0; exp_busy = 1'b0;
    none = pk(4'h0, 0, 48'h0, -1, -1, 0);

    // Byte 0 of an unstalled packet is pushed on cycle 4+PAD+7 and visible one cycle later.
    vt[0] = mkv(pk(4'hA, 2, 48'hF05C, -1, -1, 0), none, 1, 1,
                2, 48'hF05C, 24'h0000AA, 6'b000001, 6'b000010, 0, 0, 17);
    vt[1] = mkv(pk(4'hA, 2, 48'hF05C, -1, 3, 3), none, 1, 1,
                2, 48'hF05C, 24'h0000AA, 6'b000001, 6'b000010, 0, 0, 20);
    vt[2] = mkv(pk(4'h3, 1, 48'h11, -1, -1, 0), pk(4'hC, 1, 48'h22, -1, -1, 0), 2, 1,
                2, 48'h2211, 24'h0000C3, 6'b000011, 6'b000011, 0, 0, 17);
    vt[3] = mkv(pk(4'h5, 1, 48'hFF, 4 + PAD + 5, -1, 0), pk(4'h7, 1, 48'h3A, -1, -1, 0), 2, 1,
                1, 48'h3A, 24'h000007, 6'b000001, 6'b000001, 0, 1, 32);
    vt[4] = mkv(pk(4'h9, 6, 48'h060504030201, -1, -1, 0), none, 1, 0,
                4, 48'h04030201, 24'h009999, 6'b000001, 6'b000000, 2, 0, 17);

    do_reset();
    for (int i = 0; i < 5; i++) run_vec(vt[i], i);

    // Reset in the middle of the second payload byte, with byte 0 still buffered.
    start_scenario();
    add_pkt(pk(4'h6, 2, 48'hBBAA, -1, -1, 0), 0);
    for (int i = 0; i < 4 + PAD + 12; i++) begin
      cyc_t c;
      c = cyc_q.pop_front();
      do_cycle(c);
    end
    cyc_q.delete();
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    do_reset();
    start_scenario();
    add_pkt(pk(4'hE, 1, 48'h77, -1, -1, 0), 1);
    add_idle(12, 1);
    run_q();
    chk("post_reset_beats", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) chk("post_reset_beat", 32'(obs_q[0]), 32'(mk_beat(8'h77, 4'hE, 1'b1, 1'b1)));
    chk("post_reset_err_frame_cnt", 32'(ef_cnt), 32'd0);

    // Random traffic: stalls, back-to-back packets, aborts and consumer back-pressure.
    start_scenario();
    for (int i = 0; i < 40; i++) begin
      p = pk(4'($urandom), $urandom_range(1, 6), {16'($urandom), 32'($urandom)},
             ($urandom_range(0, 4) == 0) ? -2 : -1, -1, 0);
      add_pkt(p, 2);
      add_idle($urandom_range(0, 3), 2);
    end
    add_idle(12, 1);
    run_q();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
